rs_encode_req_arb: RTL

Round-robin arbiter that shares one Reed-Solomon stream encoder between `NUM_SRCS` requesters. A request is a header beat followed by data beats, terminated by a `last` beat. The grant is held for the whole transaction: the request forwarded to the encoder, and the encoder's response (encoded data lines, then parity lines) routed back to the owning requester. The block sits between the per-flow request queues and the encoder's input/output controllers.

---
 rtl/rs_encode_req_arb_if.sv | 48 ++++
 rtl/rs_encode_req_arb.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/rs_encode_req_arb_if.sv
// Request/response bundle between the per-flow queues, the RS encoder and the arbiter.
// A beat transfers on a rising edge where its val and rdy are both high; val never waits on rdy.
interface rs_encode_req_arb_if #(
  parameter int NUM_SRCS = 4,
  parameter int DATA_W   = 512
);
  logic [NUM_SRCS-1:0]             src_arb_req_val;
  logic [NUM_SRCS-1:0][DATA_W-1:0] src_arb_req_data;
  logic [NUM_SRCS-1:0]             src_arb_req_last;
  logic [NUM_SRCS-1:0]             arb_src_req_rdy;

  logic                            arb_enc_req_val;
  logic [DATA_W-1:0]               arb_enc_req_data;
  logic                            arb_enc_req_last;
  logic                            enc_arb_req_rdy;

  logic                            enc_arb_resp_val;
  logic [DATA_W-1:0]               enc_arb_resp_data;
  logic                            enc_arb_resp_last;
  logic                            arb_enc_resp_rdy;

  logic [NUM_SRCS-1:0]             arb_dst_resp_val;
  logic                            arb_dst_resp_last;
  logic [DATA_W-1:0]               arb_dst_resp_data;
  logic [NUM_SRCS-1:0]             dst_arb_resp_rdy;

  modport slave (
    input  src_arb_req_val, src_arb_req_data, src_arb_req_last,
    output arb_src_req_rdy,
    output arb_enc_req_val, arb_enc_req_data, arb_enc_req_last,
    input  enc_arb_req_rdy,
    input  enc_arb_resp_val, enc_arb_resp_data, enc_arb_resp_last,
    output arb_enc_resp_rdy,
    output arb_dst_resp_val, arb_dst_resp_last, arb_dst_resp_data,
    input  dst_arb_resp_rdy
  );

  modport master (
    output src_arb_req_val, src_arb_req_data, src_arb_req_last,
    input  arb_src_req_rdy,
    input  arb_enc_req_val, arb_enc_req_data, arb_enc_req_last,
    output enc_arb_req_rdy,
    output enc_arb_resp_val, enc_arb_resp_data, enc_arb_resp_last,
    input  arb_enc_resp_rdy,
    input  arb_dst_resp_val, arb_dst_resp_last, arb_dst_resp_data,
    output dst_arb_resp_rdy
  );
endinterface

// File: rtl/rs_encode_req_arb.sv
// Round-robin arbiter sharing one RS stream encoder; the grant covers request and response.
// Optional performance counters are built when RS_ENC_ARB_PERF_EN is defined.
module rs_encode_req_arb #(
  parameter int NUM_SRCS = 4,
  parameter int DATA_W   = 512,
  parameter int SRC_W    = $clog2(NUM_SRCS)
) (
  input  logic                clk,
  input  logic                rst,
  rs_encode_req_arb_if.slave  bus,
  output logic                arb_busy,
  output logic                dbg_state,
  output logic [SRC_W-1:0]    dbg_owner,
  output logic [SRC_W-1:0]    dbg_prio_ptr
`ifdef RS_ENC_ARB_PERF_EN
  ,
  output logic [NUM_SRCS-1:0][31:0] arb_grant_cnt,
  output logic [31:0]               arb_busy_cycles
`endif
);

  typedef enum logic {IDLE = 1'b0, ACTIVE = 1'b1} state_t;

  state_t             state_q, state_d;
  logic [SRC_W-1:0]   owner_q, owner_d;
  logic [SRC_W-1:0]   prio_q, prio_d;
  logic               req_done_q, req_done_d;
  logic               resp_done_q, resp_done_d;

  logic               grant_found;
  logic [SRC_W-1:0]   grant_idx;
  logic [SRC_W:0]     scan_sum;
  logic               req_hs;
  logic               resp_hs;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      owner_q     <= '0;
      prio_q      <= '0;
      req_done_q  <= 1'b0;
      resp_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      prio_q      <= prio_d;
      req_done_q  <= req_done_d;
      resp_done_q <= resp_done_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    prio_d      = prio_q;
    req_done_d  = req_done_q;
    resp_done_d = resp_done_q;
    grant_found = 1'b0;
    grant_idx   = '0;
    scan_sum    = '0;
    req_hs      = 1'b0;
    resp_hs     = 1'b0;

    bus.arb_src_req_rdy   = '0;
    bus.arb_enc_req_val   = 1'b0;
    bus.arb_enc_req_data  = '0;
    bus.arb_enc_req_last  = 1'b0;
    bus.arb_enc_resp_rdy  = 1'b0;
    bus.arb_dst_resp_val  = '0;
    bus.arb_dst_resp_last = 1'b0;
    bus.arb_dst_resp_data = '0;

    case (state_q)
      IDLE: begin
        // Scan prio_ptr, prio_ptr+1, ... modulo NUM_SRCS; first requester wins.
        for (int k = 0; k < NUM_SRCS; k++) begin
          scan_sum = {1'b0, prio_q} + (SRC_W+1)'(k);
          if (scan_sum >= (SRC_W+1)'(NUM_SRCS)) begin
            scan_sum = scan_sum - (SRC_W+1)'(NUM_SRCS);
          end
          if (!grant_found && bus.src_arb_req_val[scan_sum[SRC_W-1:0]]) begin
            grant_found = 1'b1;
            grant_idx   = scan_sum[SRC_W-1:0];
          end
        end
        if (grant_found) begin
          owner_d     = grant_idx;
          req_done_d  = 1'b0;
          resp_done_d = 1'b0;
          state_d     = ACTIVE;
        end
      end

      ACTIVE: begin
        bus.arb_enc_req_data = bus.src_arb_req_data[owner_q];
        bus.arb_enc_req_last = bus.src_arb_req_last[owner_q];
        if (!req_done_q) begin
          bus.arb_enc_req_val          = bus.src_arb_req_val[owner_q];
          bus.arb_src_req_rdy[owner_q] = bus.enc_arb_req_rdy;
        end
        req_hs = !req_done_q && bus.src_arb_req_val[owner_q] && bus.enc_arb_req_rdy;

        // Responses overlap the request stream; once done they are held at the encoder.
        bus.arb_dst_resp_data = bus.enc_arb_resp_data;
        bus.arb_dst_resp_last = bus.enc_arb_resp_last;
        if (!resp_done_q) begin
          bus.arb_dst_resp_val[owner_q] = bus.enc_arb_resp_val;
          bus.arb_enc_resp_rdy          = bus.dst_arb_resp_rdy[owner_q];
        end
        resp_hs = !resp_done_q && bus.enc_arb_resp_val && bus.dst_arb_resp_rdy[owner_q];

        if (req_hs && bus.src_arb_req_last[owner_q]) req_done_d = 1'b1;
        if (resp_hs && bus.enc_arb_resp_last)       resp_done_d = 1'b1;

        if (req_done_d && resp_done_d) begin
          state_d = IDLE;
          prio_d  = (owner_q == SRC_W'(NUM_SRCS-1)) ? '0 : owner_q + 1'b1;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  assign arb_busy     = (state_q == ACTIVE);
  assign dbg_state    = (state_q == ACTIVE);
  assign dbg_owner    = owner_q;
  assign dbg_prio_ptr = prio_q;

`ifdef RS_ENC_ARB_PERF_EN
  logic [NUM_SRCS-1:0][31:0] grant_cnt_q, grant_cnt_d;
  logic [31:0]               busy_cycles_q, busy_cycles_d;

  always_comb begin
    grant_cnt_d   = grant_cnt_q;
    busy_cycles_d = busy_cycles_q + ((state_q == ACTIVE) ? 32'd1 : 32'd0);
    if ((state_q == IDLE) && grant_found) begin
      grant_cnt_d[grant_idx] = grant_cnt_q[grant_idx] + 32'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      grant_cnt_q   <= '0;
      busy_cycles_q <= '0;
    end else begin
      grant_cnt_q   <= grant_cnt_d;
      busy_cycles_q <= busy_cycles_d;
    end
  end

  assign arb_grant_cnt   = grant_cnt_q;
  assign arb_busy_cycles = busy_cycles_q;
`endif

endmodule
